// File: rtl/io_pkg.sv
// Shared types and constants for the processor input-port byte source.
package io_pkg;

    localparam int IO_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        REL  = 2'b10
    } io_state_t;

endpackage

// File: rtl/io_byte_fifo.sv
// Circular DEPTH x IO_W FIFO; the head word is visible combinationally so the
// consumer can register it on the same edge that pops it.
module io_byte_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       g_clk,
    input  logic                       g_clr,
    input  logic                       i_push,
    input  logic [IO_W-1:0]            i_wr_data,
    input  logic                       i_pop,
    output logic [IO_W-1:0]            o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [IO_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A push while full is refused even if a pop frees a slot on the same edge.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/io_input_device.sv
// Buffered byte source driving the in_dev_hs / in_dev_ack / input_bus
// four-phase handshake toward the processor input port.
module io_input_device
    import io_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int GAP     = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                       g_clk,
    input  logic                       g_clr,
    input  logic                       wr_en,
    input  logic [IO_W-1:0]            wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       in_dev_ack,
    output logic                       in_dev_hs,
    output logic [IO_W-1:0]            input_bus,
    output logic [7:0]                 sent_cnt,
    output logic                       ovf_err,
    output logic                       ack_err
);

    localparam int GW = (GAP > 0) ? $clog2(GAP+1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

    io_state_t       r_state;
    io_state_t       w_state_next;
    logic            r_hs;
    logic [IO_W-1:0] r_bus;
    logic [7:0]      r_sent;
    logic            r_ovf;
    logic            r_ack_err;
    logic [GW-1:0]   r_gap;
    logic [TW-1:0]   r_timer;

    logic [IO_W-1:0] w_head;
    logic            w_pop;
    logic            w_ack_take;
    logic            w_release;
    logic            w_timer_run;

    io_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .g_clk     (g_clk),
        .g_clr     (g_clr),
        .i_push    (wr_en),
        .i_wr_data (wr_data),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_count   (count),
        .o_full    (full),
        .o_empty   (empty)
    );

    always_ff @(posedge g_clk) begin
        if (g_clr) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!empty && r_gap == '0) w_state_next = REQ;
            REQ:     if (in_dev_ack)            w_state_next = REL;
            REL:     if (!in_dev_ack)           w_state_next = IDLE;
            default:                            w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop       = (r_state == IDLE) && !empty && (r_gap == '0);
        w_ack_take  = (r_state == REQ) && in_dev_ack;
        w_release   = (r_state == REL) && !in_dev_ack;
        w_timer_run = (TIMEOUT > 0) && (r_state == REQ) && !in_dev_ack
                      && (r_timer != TW'(TIMEOUT));
    end

    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_hs      <= 1'b0;
            r_bus     <= '0;
            r_sent    <= '0;
            r_ovf     <= 1'b0;
            r_ack_err <= 1'b0;
            r_gap     <= '0;
            r_timer   <= '0;
        end else begin
            if (wr_en && full) r_ovf <= 1'b1;

            if (w_pop) begin
                r_bus   <= w_head;
                r_hs    <= 1'b1;
                r_timer <= '0;
            end else if (r_state == IDLE && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end

            if (w_ack_take) begin
                r_hs   <= 1'b0;
                r_sent <= r_sent + 8'd1;
            end

            // Timer saturates at TIMEOUT; the byte keeps being offered afterwards.
            if (w_timer_run) begin
                r_timer <= r_timer + 1'b1;
                if (r_timer == TW'(TIMEOUT - 1)) r_ack_err <= 1'b1;
            end

            if (w_release) r_gap <= GW'(GAP);
        end
    end

    assign in_dev_hs = r_hs;
    assign input_bus = r_bus;
    assign sent_cnt  = r_sent;
    assign ovf_err   = r_ovf;
    assign ack_err   = r_ack_err;

endmodule

// File: tb/tb_io_input_device.sv
// Directed bench for io_input_device: a GAP=0 instance for most scenarios and
// a GAP=3 instance for the inter-transfer gap timing.
module tb_io_input_device;

    logic       clk = 1'b0;
    logic       g_clr;

    logic       wr_en, ack;
    logic [7:0] wr_data;
    logic       full, empty, hs, ovf_err, ack_err;
    logic [3:0] count;
    logic [7:0] bus, sent;

    logic       wr_en_g, ack_g;
    logic [7:0] wr_data_g;
    logic       full_g, empty_g, hs_g, ovf_err_g, ack_err_g;
    logic [3:0] count_g;
    logic [7:0] bus_g, sent_g;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_sent = 0;

    always #5 clk = ~clk;

    io_input_device #(.DEPTH(8), .GAP(0), .TIMEOUT(255)) dut (
        .g_clk(clk), .g_clr(g_clr), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .in_dev_ack(ack),
        .in_dev_hs(hs), .input_bus(bus), .sent_cnt(sent),
        .ovf_err(ovf_err), .ack_err(ack_err)
    );

    io_input_device #(.DEPTH(8), .GAP(3), .TIMEOUT(255)) dut_g (
        .g_clk(clk), .g_clr(g_clr), .wr_en(wr_en_g), .wr_data(wr_data_g),
        .full(full_g), .empty(empty_g), .count(count_g), .in_dev_ack(ack_g),
        .in_dev_hs(hs_g), .input_bus(bus_g), .sent_cnt(sent_g),
        .ovf_err(ovf_err_g), .ack_err(ack_err_g)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
        $display("push 0x%02h count=%0d full=%0b ovf=%0b", b, count, full, ovf_err);
    endtask

    // Processor model: wait for hs (lat = cycles waited), take the byte,
    // ack for one edge, then drop ack for one edge.
    task automatic recv(output logic [7:0] b, output int lat);
        lat = 0;
        while (!hs && lat < 1000) begin
            step();
            lat++;
        end
        if (!hs) check("hs_wait_timeout", 32'(hs), 32'd1);
        b   = bus;
        ack = 1'b1;
        step();
        check("hs_fall_after_ack", 32'(hs), 32'd0);
        exp_sent++;
        ack = 1'b0;
        step();
        $display("recv 0x%02h lat=%0d sent=%0d", b, lat, sent);
    endtask

    initial begin
        logic [7:0] b;
        int         lat;
        int         n;

        g_clr = 1'b1; wr_en = 1'b0; wr_data = '0; ack = 1'b0;
        wr_en_g = 1'b0; wr_data_g = '0; ack_g = 1'b0;
        step();
        g_clr = 1'b0;
        check("rst_hs",    32'(hs),      32'd0);
        check("rst_bus",   32'(bus),     32'd0);
        check("rst_count", 32'(count),   32'd0);
        check("rst_empty", 32'(empty),   32'd1);
        check("rst_full",  32'(full),    32'd0);
        check("rst_sent",  32'(sent),    32'd0);
        check("rst_ovf",   32'(ovf_err), 32'd0);
        check("rst_ackerr",32'(ack_err), 32'd0);

        // Single byte: count=1 at k+1, hs at k+2.
        push(8'h3C);
        check("t1_count_k1", 32'(count), 32'd1);
        check("t1_hs_k1",    32'(hs),    32'd0);
        step();
        check("t1_hs_k2",    32'(hs),    32'd1);
        check("t1_bus",      32'(bus),   32'h3C);
        step(); step();
        ack = 1'b1;
        step();
        check("t1_hs_fall",  32'(hs),    32'd0);
        exp_sent++;
        check("t1_sent",     32'(sent),  32'(exp_sent));
        ack = 1'b0;
        step();
        check("t1_empty",    32'(empty), 32'd1);
        $display("t1 single byte done sent=%0d", sent);

        // GAP=3: second hs rises 5 cycles after ack is seen low.
        wr_en_g = 1'b1; wr_data_g = 8'hA5; step();
        wr_data_g = 8'h5A; step();
        wr_en_g = 1'b0;
        n = 0;
        while (!hs_g && n < 50) begin step(); n++; end
        check("t3_bus_first", 32'(bus_g), 32'hA5);
        ack_g = 1'b1; step();
        ack_g = 1'b0; step();
        n = 1;
        while (!hs_g && n < 50) begin step(); n++; end
        check("t3_gap_cycles", 32'(n), 32'd5);
        check("t3_bus_second", 32'(bus_g), 32'h5A);
        ack_g = 1'b1; step();
        ack_g = 1'b0; step();
        check("t3_sent", 32'(sent_g), 32'd2);
        $display("t3 gap measured %0d cycles", n);

        // Overflow: a sentinel occupies the interface so eight pushes fill the FIFO.
        push(8'h00);
        step();
        check("t2_sentinel_hs", 32'(hs), 32'd1);
        for (int i = 1; i <= 8; i++) push(8'(i));
        check("t2_count_full", 32'(count), 32'd8);
        check("t2_full",       32'(full),  32'd1);
        check("t2_ovf_before", 32'(ovf_err), 32'd0);
        push(8'hFF);
        check("t2_ovf",        32'(ovf_err), 32'd1);
        check("t2_count_kept", 32'(count), 32'd8);
        recv(b, lat);
        check("t2_sentinel", 32'(b), 32'h00);
        for (int i = 1; i <= 8; i++) begin
            recv(b, lat);
            check("t2_data", 32'(b), 32'(i));
            check("t2_lat",  32'(lat), 32'd1);
        end
        check("t2_sent",  32'(sent),  32'(exp_sent));
        check("t2_empty", 32'(empty), 32'd1);
        step(); step();
        check("t2_no_ff_hs", 32'(hs), 32'd0);

        // Ack timeout: byte held stable, ack_err after 255 REQ cycles.
        push(8'h77);
        step();
        check("t4_hs", 32'(hs), 32'd1);
        for (int i = 0; i < 250; i++) step();
        check("t4_ackerr_early", 32'(ack_err), 32'd0);
        for (int i = 0; i < 50; i++) step();
        check("t4_ackerr", 32'(ack_err), 32'd1);
        check("t4_hs_held", 32'(hs), 32'd1);
        check("t4_bus_held", 32'(bus), 32'h77);
        recv(b, lat);
        check("t4_late_ack_data", 32'(b), 32'h77);
        check("t4_sent", 32'(sent), 32'(exp_sent));

        // Reset mid-REQ with three bytes queued.
        for (int i = 0; i < 4; i++) push(8'hB1 + 8'(i));
        step();
        check("t5_hs",    32'(hs),    32'd1);
        check("t5_count", 32'(count), 32'd3);
        g_clr = 1'b1; step(); g_clr = 1'b0;
        exp_sent = 0;
        check("t5_hs_clr",    32'(hs),      32'd0);
        check("t5_count_clr", 32'(count),   32'd0);
        check("t5_bus_clr",   32'(bus),     32'd0);
        check("t5_sent_clr",  32'(sent),    32'd0);
        check("t5_ovf_clr",   32'(ovf_err), 32'd0);
        check("t5_ackerr_clr",32'(ack_err), 32'd0);
        ack = 1'b1; step(); step(); step();
        check("t5_late_ack_hs",   32'(hs),   32'd0);
        check("t5_late_ack_sent", 32'(sent), 32'd0);
        ack = 1'b0; step();
        $display("t5 reset mid-transfer done");

        // Ack stuck high through REL must block the next transfer.
        push(8'hC1); push(8'hC2);
        check("t6_hs", 32'(hs), 32'd1);
        check("t6_bus", 32'(bus), 32'hC1);
        ack = 1'b1; step();
        exp_sent++;
        for (int i = 0; i < 4; i++) step();
        check("t6_hs_blocked",    32'(hs),    32'd0);
        check("t6_count_blocked", 32'(count), 32'd1);
        ack = 1'b0; step();
        check("t6_hs_m1", 32'(hs), 32'd0);
        step();
        check("t6_hs_m2", 32'(hs), 32'd1);
        check("t6_bus2",  32'(bus), 32'hC2);
        recv(b, lat);
        check("t6_sent", 32'(sent), 32'(exp_sent));

        // 258 more transfers: 260 total since reset, sent_cnt wraps to 4.
        for (int i = 0; i < 258; i++) begin
            push(8'(i));
            recv(b, lat);
            check("t6_wrap_data", 32'(b), 32'(i[7:0]));
        end
        check("t6_wrap_sent", 32'(sent), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
